// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message sequencer and its block packer.
package sha256_pkg;

  localparam int SHA_BLOCK_W  = 512;
  localparam int SHA_DIGEST_W = 256;
  localparam int LEN_FIELD_W  = 64;
  localparam int BLOCK_BYTES  = 64;

  localparam logic [7:0] PAD_BYTE      = 8'h80;
  localparam logic [5:0] LAST_BYTE_IDX = 6'd63;
  // Highest byte position for 0x80 that still leaves room for the length field
  localparam logic [5:0] LAST_PAD_IDX  = 6'd55;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    PAD    = 3'd2,
    LEN    = 3'd3,
    KICK   = 3'd4,
    WAIT   = 3'd5,
    DIGEST = 3'd6
  } seq_state_e;

  typedef enum logic [2:0] {
    PK_NONE  = 3'd0,
    PK_CLEAR = 3'd1,
    PK_WRITE = 3'd2,
    PK_PAD   = 3'd3,
    PK_LEN   = 3'd4
  } pack_op_e;

endpackage

// File: rtl/sha256_block_packer.sv
// 512-bit block buffer: byte writes (byte 0 = MSB), 0x80 padding with zero fill,
// and insertion of the 64-bit length field.
module sha256_block_packer
  import sha256_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  pack_op_e               op,
  input  logic [5:0]             idx,
  input  logic [7:0]             data,
  input  logic [LEN_FIELD_W-1:0] len_bits,
  output logic [SHA_BLOCK_W-1:0] block
);

  // Buffer update; padding zeroes every byte that follows the 0x80 marker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block <= '0;
    end else begin
      case (op)
        PK_CLEAR: block <= '0;
        PK_WRITE: begin
          for (int b = 0; b < BLOCK_BYTES; b++) begin
            if (6'(b) == idx) block[SHA_BLOCK_W-1-8*b -: 8] <= data;
          end
        end
        PK_PAD: begin
          for (int b = 0; b < BLOCK_BYTES; b++) begin
            if (6'(b) == idx)     block[SHA_BLOCK_W-1-8*b -: 8] <= PAD_BYTE;
            else if (6'(b) > idx) block[SHA_BLOCK_W-1-8*b -: 8] <= 8'h00;
          end
        end
        PK_LEN:  block[LEN_FIELD_W-1:0] <= len_bits;
        default: block <= block;
      endcase
    end
  end

endmodule

// File: rtl/sha256_msg_sequencer.sv
// Byte-stream front end and controller for an iterated SHA-256 compression core.
// Optional macro SHA_SEQ_ABORT_EN adds an abort input that drains the core and returns to IDLE.
module sha256_msg_sequencer
  import sha256_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  input  logic                    in_keep,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    core_start,
  output logic                    core_first,
  output logic [SHA_BLOCK_W-1:0]  core_block,
  input  logic [SHA_DIGEST_W-1:0] core_hash,
  input  logic                    core_ready,
  output logic [SHA_DIGEST_W-1:0] digest,
  output logic                    digest_valid,
  input  logic                    digest_ack,
`ifdef SHA_SEQ_ABORT_EN
  input  logic                    abort,
`endif
  output logic                    busy
);

  localparam logic [LEN_W-1:0] COUNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  seq_state_e             state;
  logic [5:0]             idx;
  logic [LEN_W-1:0]       byte_count;
  logic                   first_blk;
  logic                   last_blk;
  logic                   len_pending;
  logic                   pending_pad;
  logic                   ready_low_seen;
`ifdef SHA_SEQ_ABORT_EN
  logic                   draining;
`endif

  logic                   beat;
  logic                   wait_done;
  pack_op_e               pk_op;
  logic [LEN_FIELD_W-1:0] len_bits;

  assign beat      = in_valid && in_ready;
  assign wait_done = ready_low_seen && core_ready;
  assign len_bits  = {{(LEN_FIELD_W-LEN_W-3){1'b0}}, byte_count, 3'b000};

  // Buffer operation requested by the current state
  always_comb begin
    pk_op = PK_NONE;
    case (state)
      IDLE, FILL: begin
        if (beat && in_keep) pk_op = PK_WRITE;
        else                 pk_op = PK_NONE;
      end
      PAD: pk_op = PK_PAD;
      LEN: pk_op = PK_LEN;
      WAIT: begin
        if (wait_done && !last_blk && len_pending) pk_op = PK_CLEAR;
        else                                       pk_op = PK_NONE;
      end
      default: pk_op = PK_NONE;
    endcase
  end

  sha256_block_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .op       (pk_op),
    .idx      (idx),
    .data     (in_data),
    .len_bits (len_bits),
    .block    (core_block)
  );

  // Sequencer FSM with registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      in_ready       <= 1'b1;
      core_start     <= 1'b0;
      core_first     <= 1'b0;
      digest         <= '0;
      digest_valid   <= 1'b0;
      busy           <= 1'b0;
      idx            <= 6'd0;
      byte_count     <= '0;
      first_blk      <= 1'b1;
      last_blk       <= 1'b0;
      len_pending    <= 1'b0;
      pending_pad    <= 1'b0;
      ready_low_seen <= 1'b0;
`ifdef SHA_SEQ_ABORT_EN
      draining       <= 1'b0;
`endif
    end
`ifdef SHA_SEQ_ABORT_EN
    else if (abort) begin
      state        <= IDLE;
      idx          <= 6'd0;
      byte_count   <= '0;
      first_blk    <= 1'b1;
      last_blk     <= 1'b0;
      len_pending  <= 1'b0;
      pending_pad  <= 1'b0;
      digest_valid <= 1'b0;
      core_first   <= 1'b0;
      // A started core must be allowed to finish before it can take a new block
      if (core_start) begin
        draining <= 1'b1;
        in_ready <= 1'b0;
        busy     <= 1'b1;
      end else begin
        draining <= 1'b0;
        in_ready <= 1'b1;
        busy     <= 1'b0;
      end
    end else if (draining) begin
      if (!core_ready) begin
        ready_low_seen <= 1'b1;
      end else if (ready_low_seen) begin
        core_start <= 1'b0;
        draining   <= 1'b0;
        in_ready   <= 1'b1;
        busy       <= 1'b0;
      end else begin
        ready_low_seen <= ready_low_seen;
      end
    end
`endif
    else begin
      case (state)
        IDLE, FILL: begin
          if (beat && in_keep) begin
            idx <= idx + 6'd1;
            if (byte_count != '1) byte_count <= byte_count + COUNT_ONE;
            busy <= 1'b1;
            if (idx == LAST_BYTE_IDX) begin
              state       <= KICK;
              in_ready    <= 1'b0;
              pending_pad <= in_last;
            end else if (in_last) begin
              state    <= PAD;
              in_ready <= 1'b0;
            end else begin
              state <= FILL;
            end
          end else if (beat && in_last) begin
            state    <= PAD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end else begin
            state <= state;
          end
        end
        PAD: begin
          pending_pad <= 1'b0;
          if (idx <= LAST_PAD_IDX) begin
            state <= LEN;
          end else begin
            state       <= KICK;
            len_pending <= 1'b1;
          end
        end
        LEN: begin
          last_blk <= 1'b1;
          state    <= KICK;
        end
        KICK: begin
          core_start     <= 1'b1;
          core_first     <= first_blk;
          ready_low_seen <= 1'b0;
          state          <= WAIT;
        end
        WAIT: begin
          // Ready must be seen low first so a stale ready from the previous block is ignored
          if (!core_ready) begin
            ready_low_seen <= 1'b1;
          end else if (ready_low_seen) begin
            core_start <= 1'b0;
            core_first <= 1'b0;
            first_blk  <= 1'b0;
            if (last_blk) begin
              state        <= DIGEST;
              digest       <= core_hash;
              digest_valid <= 1'b1;
            end else if (len_pending) begin
              len_pending <= 1'b0;
              state       <= LEN;
            end else if (pending_pad) begin
              state <= PAD;
            end else begin
              state    <= FILL;
              in_ready <= 1'b1;
            end
          end else begin
            ready_low_seen <= ready_low_seen;
          end
        end
        DIGEST: begin
          if (digest_ack) begin
            digest_valid <= 1'b0;
            state        <= IDLE;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
            idx          <= 6'd0;
            byte_count   <= '0;
            first_blk    <= 1'b1;
            last_blk     <= 1'b0;
            len_pending  <= 1'b0;
            pending_pad  <= 1'b0;
          end else begin
            state <= DIGEST;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Directed bench for sha256_msg_sequencer with a behavioural SHA-256 core model.
module tb_sha256_msg_sequencer;
  import sha256_pkg::*;

  localparam logic [255:0] SHA_IV    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_448   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_keep, in_last, in_ready;
  logic [7:0]   in_data;
  logic         core_start, core_first, core_ready;
  logic [511:0] core_block;
  logic [255:0] core_hash, digest;
  logic         digest_valid, digest_ack, busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   msg [0:63];
  logic [511:0] kick_blk   [0:31];
  logic         kick_first [0:31];
  int           kicks = 0;

  logic         cm_busy, cm_armed;
  int           cm_cnt;
  logic [255:0] cm_res;

  always #5 clk = ~clk;

  sha256_msg_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_keep      (in_keep),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .core_start   (core_start),
    .core_first   (core_first),
    .core_block   (core_block),
    .core_hash    (core_hash),
    .core_ready   (core_ready),
    .digest       (digest),
    .digest_valid (digest_valid),
    .digest_ack   (digest_ack),
    .busy         (busy)
  );

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Core model: accepts a fresh start, drops ready, returns the hash 66 cycles later
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_ready <= 1'b1;
      core_hash  <= '0;
      cm_busy    <= 1'b0;
      cm_armed   <= 1'b1;
      cm_cnt     <= 0;
      cm_res     <= '0;
    end else begin
      if (!core_start) cm_armed <= 1'b1;
      if (cm_busy) begin
        cm_cnt <= cm_cnt + 1;
        if (cm_cnt == 65) begin
          cm_busy    <= 1'b0;
          core_ready <= 1'b1;
          core_hash  <= cm_res;
        end
      end else if (core_start && cm_armed) begin
        cm_busy    <= 1'b1;
        cm_armed   <= 1'b0;
        core_ready <= 1'b0;
        cm_cnt     <= 0;
        cm_res     <= sha_compress(core_first ? SHA_IV : core_hash, core_block);
        if (kicks < 32) begin
          kick_blk[kicks]   <= core_block;
          kick_first[kicks] <= core_first;
        end
        kicks <= kicks + 1;
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic k, input logic l);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
    while (!in_ready && t < 500) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, t);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_msg(input int n);
    if (n == 0) send_beat(8'h00, 1'b0, 1'b1);
    else for (int i = 0; i < n; i++) send_beat(msg[i], 1'b1, i == n - 1);
  endtask

  task automatic wait_digest();
    int t = 0;
    while (!digest_valid && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    n_cmp++;
    if (!digest_valid) begin
      n_bad++;
      $display("FAIL digest_timeout: digest_valid=%0b after %0d cycles, required 1", digest_valid, t);
    end
  endtask

  task automatic ack_digest();
    digest_ack = 1'b1;
    @(posedge clk); #1;
    digest_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({in_ready, core_start, core_first, digest_valid, busy} !== 5'b10000) begin
      n_bad++; $display("FAIL reset_flags: {in_ready,start,first,dvalid,busy}=%b, required 10000",
                        {in_ready, core_start, core_first, digest_valid, busy});
    end
    n_cmp++; if (core_block !== 512'd0) begin
      n_bad++; $display("FAIL reset_block: core_block=%h, required 0", core_block);
    end
    n_cmp++; if (digest !== 256'd0) begin
      n_bad++; $display("FAIL reset_digest: digest=%h, required 0", digest);
    end
    digest_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 digest_ack = 1'b0;
    n_cmp++; if ({in_ready, digest_valid, busy} !== 3'b100) begin
      n_bad++; $display("FAIL idle_ack_ignored: {in_ready,dvalid,busy}=%b, required 100",
                        {in_ready, digest_valid, busy});
    end
  endtask

  task automatic test_abc();
    logic [511:0] exp_blk;
    int k0;
    exp_blk = '0;
    exp_blk[511:480] = 32'h61626380;
    exp_blk[63:0]    = 64'h18;
    k0 = kicks;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3);
    wait_digest();
    n_cmp++; if (kicks - k0 !== 1) begin
      n_bad++; $display("FAIL abc_kicks: %0d blocks, required 1", kicks - k0);
    end
    n_cmp++; if (kick_blk[k0] !== exp_blk) begin
      n_bad++; $display("FAIL abc_block: got %h required %h", kick_blk[k0], exp_blk);
    end
    n_cmp++; if (kick_first[k0] !== 1'b1) begin
      n_bad++; $display("FAIL abc_first: core_first=%0b, required 1", kick_first[k0]);
    end
    n_cmp++; if (digest !== DIG_ABC) begin
      n_bad++; $display("FAIL abc_digest: got %h required %h", digest, DIG_ABC);
    end
  endtask

  task automatic test_digest_hold();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_cmp++; if ({digest_valid, in_ready, busy} !== 3'b101 || digest !== DIG_ABC) begin
        n_bad++; $display("FAIL hold_cycle%0d: {dvalid,in_ready,busy}=%b digest=%h, required 101 and %h",
                          i, {digest_valid, in_ready, busy}, digest, DIG_ABC);
      end
    end
    ack_digest();
    n_cmp++; if ({digest_valid, in_ready, busy} !== 3'b010) begin
      n_bad++; $display("FAIL hold_ack: {dvalid,in_ready,busy}=%b, required 010", {digest_valid, in_ready, busy});
    end
  endtask

  task automatic test_empty();
    logic [511:0] exp_blk;
    int k0;
    exp_blk = '0;
    exp_blk[511:504] = 8'h80;
    k0 = kicks;
    send_msg(0);
    wait_digest();
    n_cmp++; if (kicks - k0 !== 1 || kick_blk[k0] !== exp_blk) begin
      n_bad++; $display("FAIL empty_block: %0d blocks, block %h, required 1 block %h", kicks - k0, kick_blk[k0], exp_blk);
    end
    n_cmp++; if (digest !== DIG_EMPTY) begin
      n_bad++; $display("FAIL empty_digest: got %h required %h", digest, DIG_EMPTY);
    end
    ack_digest();
  endtask

  task automatic test_two_block_pad();
    logic [511:0] exp0, exp1;
    string s;
    int k0;
    s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    exp0 = '0;
    for (int i = 0; i < 56; i++) begin
      msg[i] = s[i];
      exp0[511-8*i -: 8] = s[i];
    end
    exp0[63:56] = 8'h80;
    exp1 = '0;
    exp1[63:0] = 64'h1C0;
    k0 = kicks;
    send_msg(56);
    wait_digest();
    n_cmp++; if (kicks - k0 !== 2) begin
      n_bad++; $display("FAIL m56_kicks: %0d blocks, required 2", kicks - k0);
    end
    n_cmp++; if (kick_blk[k0] !== exp0) begin
      n_bad++; $display("FAIL m56_block0: got %h required %h", kick_blk[k0], exp0);
    end
    n_cmp++; if (kick_blk[k0+1] !== exp1) begin
      n_bad++; $display("FAIL m56_block1: got %h required %h", kick_blk[k0+1], exp1);
    end
    n_cmp++; if (digest !== DIG_448) begin
      n_bad++; $display("FAIL m56_digest: got %h required %h", digest, DIG_448);
    end
    ack_digest();
  endtask

  task automatic test_full_block();
    logic [511:0] exp0, exp1;
    logic [255:0] exp_dig;
    int k0;
    for (int i = 0; i < 64; i++) begin
      msg[i] = 8'(i * 3 + 1);
      exp0[511-8*i -: 8] = 8'(i * 3 + 1);
    end
    exp1 = '0;
    exp1[511:504] = 8'h80;
    exp1[63:0]    = 64'h200;
    exp_dig = sha_compress(sha_compress(SHA_IV, exp0), exp1);
    k0 = kicks;
    send_msg(64);
    wait_digest();
    n_cmp++; if (kicks - k0 !== 2 || kick_blk[k0] !== exp0) begin
      n_bad++; $display("FAIL m64_block0: %0d blocks, block %h, required 2 blocks, %h", kicks - k0, kick_blk[k0], exp0);
    end
    n_cmp++; if (kick_blk[k0+1] !== exp1) begin
      n_bad++; $display("FAIL m64_block1: got %h required %h", kick_blk[k0+1], exp1);
    end
    n_cmp++; if ({kick_first[k0], kick_first[k0+1]} !== 2'b10) begin
      n_bad++; $display("FAIL m64_first: first flags %b, required 10", {kick_first[k0], kick_first[k0+1]});
    end
    n_cmp++; if (digest !== exp_dig) begin
      n_bad++; $display("FAIL m64_digest: got %h required %h", digest, exp_dig);
    end
    ack_digest();
  endtask

  task automatic test_reset_in_wait();
    int t = 0;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3);
    while (!(core_start && !core_ready) && t < 500) begin
      @(posedge clk); #1; t++;
    end
    n_cmp++; if (!(core_start && !core_ready)) begin
      n_bad++; $display("FAIL rstwait_reach: start=%0b ready=%0b, required 1 and 0", core_start, core_ready);
    end
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++; if ({core_start, digest_valid, busy, in_ready} !== 4'b0001) begin
      n_bad++; $display("FAIL rstwait_async: {start,dvalid,busy,in_ready}=%b, required 0001",
                        {core_start, digest_valid, busy, in_ready});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_msg(3);
    wait_digest();
    n_cmp++; if (digest !== DIG_ABC) begin
      n_bad++; $display("FAIL rstwait_digest: got %h required %h", digest, DIG_ABC);
    end
    ack_digest();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_keep = 1'b0; in_last = 1'b0; digest_ack = 1'b0;
    test_reset();
    test_abc();
    test_digest_hold();
    test_empty();
    test_two_block_pad();
    test_full_block();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
